pool_act_nch: RTL and testbench
===============================

Name: pool_act_nch

Overview:
- Parametrised successor of the 2x2 max-pool/ReLU stage: takes a raster-scanned multi-channel conv feature map, one pixel (all channels) per valid beat, and emits 2x2/stride-2 pooled pixels.
- Adds runtime-selectable max/average pooling, an optional ReLU bypass, arbitrary channel count on a flattened bus, and frame tracking with a last-pixel marker.
- Sits between the conv engine and the next conv layer or the flatten/FC stage.

Parameters:
- DATA_W, 12, signed sample width per channel (in and out).
- CH, 3, channel count.
- WIDTH, 24, input feature-map width in pixels; must be even and at least 2.
- HEIGHT, 24, input feature-map height in rows; must be even and at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- valid_in  in  1  input pixel beat.
- data_in  in  CH*DATA_W  signed samples; channel k occupies bits [k*DATA_W +: DATA_W].
- mode_avg  in  1  0 = max pool, 1 = average pool; sampled at frame start.
- relu_en  in  1  1 = clamp negative results to 0; sampled at frame start.
- data_out  out  CH*DATA_W  pooled (and optionally rectified) samples, same packing as data_in.
- valid_out  out  1  one-cycle pulse per pooled pixel.
- last_out  out  1  high with valid_out on the final pooled pixel of a frame.

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset clears col/row counters, valid_out, last_out, data_out and the latched mode/relu bits. Row-buffer contents are don't-care after reset.
- Input order is raster: col 0..WIDTH-1 within row, row 0..HEIGHT-1. Counters advance only on valid_in=1; idle cycles hold all state.
- At col=WIDTH-1 the col counter wraps to 0 and row increments. At row=HEIGHT-1 and col=WIDTH-1 both wrap to 0, ready for the next frame with no gap.
- Frame start is the beat with row=0 and col=0. mode_avg and relu_en are latched on that beat (the latched value applies to that beat itself); mid-frame changes are ignored.
- Storage: per channel, a row buffer of WIDTH/2 entries and one hold register, each DATA_W+2 bits signed.
- combine(a,b) = signed max(a,b) in max mode, a+b in avg mode. Sign-extend to DATA_W+2 bits before adding; the sum cannot overflow.
- Even row, even col: buf[col/2] <= x.
- Even row, odd col: buf[col/2] <= combine(buf[col/2], x).
- Odd row, even col: hold <= combine(buf[col/2], x).
- Odd row, odd col: r = combine(hold, x).
- Finalise r:
  - avg mode: arithmetic shift right by 2 (floor toward -inf).
  - max mode: no shift.
  - Then, if relu_en, r<0 -> 0.
  - Truncate to DATA_W; the value is always in range.
- Latency: data_out/valid_out are registered and appear the cycle after the odd-row/odd-col input beat. valid_out is high for exactly 1 cycle.
- last_out = valid_out on the beat that closes the frame (row=HEIGHT-1, col=WIDTH-1); otherwise 0.
- data_out holds its last value while valid_out=0.
- Reset asserted mid-frame abandons the partial frame: no output is produced for it, and counting restarts at row 0/col 0 on the first valid beat after rst deasserts. Reset in the same cycle as valid_in wins; that beat is dropped.
- All channels are processed identically and in parallel; there is no inter-channel dependency.
- Throughput: one input per cycle sustained; no backpressure.

Test Plan:
- Basic max pooling, DATA_W=12, CH=2, WIDTH=HEIGHT=4, max mode, relu_en=1, 16 back-to-back beats. ch0 = 1..16; ch1 = ch0 negated. -> ch0 out 6, 8, 14, 16; ch1 out 0, 0, 0, 0. valid_out pulses the cycle after the 6th, 8th, 14th and 16th beats; last_out is high only with the 4th output.
- Average pooling, same ch0 stimulus, mode_avg=1, relu_en=0. -> 3, 5, 11, 13 (the window sum 14 gives 3 by floor). ch1 = -1..-16 -> -4, -6, -12, -14.
- Floor rounding and ReLU bypass: one window of -1, -2, -1, -2, avg mode, relu_en=0 -> -2. Max mode with all samples -5 and relu_en=0 -> -5 (0xFFB); with relu_en=1 -> 0.
- Extremes: all samples 2047 in avg mode -> 2047. All samples -2048 in avg mode with relu_en=0 -> -2048 (no wrap).
- Gaps and latching: insert 3 idle cycles between every beat, and toggle mode_avg at beat 5 of the frame. -> Outputs are identical to the first scenario (mode stays max for this frame). valid_out never fires during idle cycles. The new mode takes effect in the next frame.
- Reset mid-frame: assert rst for 1 cycle after 7 beats, then send a full frame. -> No output for the aborted frame. The following frame yields 6, 8, 14, 16 with last_out on 16. Back-to-back second frame: its first output appears after its 6th beat.

Source files
------------

// File: rtl/pool_act_nch.sv
// 2x2 / stride-2 max-or-average pooling with optional ReLU over a raster-scanned,
// multi-channel feature map. Every channel runs through an identical lane instance.

module pool_act_lane #(
    parameter int DATA_W = 12,
    parameter int WIDTH  = 24,
    parameter int IW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              row_odd,
    input  logic              col_odd,
    input  logic [IW-1:0]     idx,
    input  logic              mode_avg,
    input  logic              relu_en,
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y
);
    localparam int AW = DATA_W + 2;

    logic signed [AW-1:0] row_buf [WIDTH/2];
    logic signed [AW-1:0] hold;
    logic signed [AW-1:0] xs, a_sel, comb, shifted, rect;

    assign xs    = {{2{x[DATA_W-1]}}, x};
    // The closing beat of a window combines with the hold register, all others with the row buffer.
    assign a_sel = (row_odd && col_odd) ? hold : row_buf[idx];
    assign comb  = mode_avg ? (a_sel + xs) : ((a_sel > xs) ? a_sel : xs);
    assign shifted = mode_avg ? (comb >>> 2) : comb;
    assign rect  = (relu_en && shifted < 0) ? '0 : shifted;

    always_ff @(posedge clk) begin
        if (valid && !rst) begin
            case ({row_odd, col_odd})
                2'b00:   row_buf[idx] <= xs;
                2'b01:   row_buf[idx] <= comb;
                2'b10:   hold         <= comb;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            y <= '0;
        else if (valid && row_odd && col_odd)
            y <= DATA_W'(rect);
    end
endmodule

module pool_act_nch #(
    parameter int DATA_W = 12,
    parameter int CH     = 3,
    parameter int WIDTH  = 24,
    parameter int HEIGHT = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [CH*DATA_W-1:0] data_in,
    input  logic                 mode_avg,
    input  logic                 relu_en,
    output logic [CH*DATA_W-1:0] data_out,
    output logic                 valid_out,
    output logic                 last_out
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH/2) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          mode_q, relu_q;
    logic          col_last, row_last, frame_start, win_done;
    logic          mode_cur, relu_cur;
    logic [IW-1:0] half;

    assign col_last    = (col == CW'(WIDTH-1));
    assign row_last    = (row == RW'(HEIGHT-1));
    assign frame_start = (col == '0) && (row == '0);
    // The frame-start beat already uses the freshly presented mode bits.
    assign mode_cur    = frame_start ? mode_avg : mode_q;
    assign relu_cur    = frame_start ? relu_en  : relu_q;
    assign win_done    = valid_in && row[0] && col[0];
    assign half        = IW'(col >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            mode_q    <= 1'b0;
            relu_q    <= 1'b0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            valid_out <= win_done;
            last_out  <= win_done && col_last && row_last;
            if (valid_in) begin
                if (frame_start) begin
                    mode_q <= mode_avg;
                    relu_q <= relu_en;
                end
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_lane
        pool_act_lane #(
            .DATA_W(DATA_W),
            .WIDTH (WIDTH),
            .IW    (IW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .valid   (valid_in),
            .row_odd (row[0]),
            .col_odd (col[0]),
            .idx     (half),
            .mode_avg(mode_cur),
            .relu_en (relu_cur),
            .x       (data_in[g*DATA_W +: DATA_W]),
            .y       (data_out[g*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_pool_act_nch.sv
// Scoreboard bench for pool_act_nch: a frame-level reference model queues expected
// pooled pixels; a negedge monitor compares every DUT output against the queue.

module tb_pool_act_nch;
    localparam int DW = 12;
    localparam int CH = 2;
    localparam int W  = 4;
    localparam int H  = 4;

    logic             clk = 1'b0;
    logic             rst, valid_in, mode_avg, relu_en;
    logic [CH*DW-1:0] data_in, data_out;
    logic             valid_out, last_out;

    always #5 clk = ~clk;

    pool_act_nch #(.DATA_W(DW), .CH(CH), .WIDTH(W), .HEIGHT(H)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .data_in  (data_in),
        .mode_avg (mode_avg),
        .relu_en  (relu_en),
        .data_out (data_out),
        .valid_out(valid_out),
        .last_out (last_out)
    );

    typedef struct {
        logic [CH*DW-1:0] d;
        bit               last;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   pix [H][W][CH];
    int   m_row, m_col;
    bit   m_mode, m_relu;
    int   n_chk, n_fail;
    bit   chk_rst, done;

    function automatic logic [CH*DW-1:0] pk(input int a, input int b);
        pk = {b[DW-1:0], a[DW-1:0]};
    endfunction

    // Reference: keep the whole frame as an image and pool each completed 2x2 window.
    task automatic model_beat(input logic [CH*DW-1:0] d, input bit m, input bit r);
        exp_t e;
        int   v0, v1, v2, v3, s, res;
        if (m_row == 0 && m_col == 0) begin
            m_mode = m;
            m_relu = r;
        end
        for (int k = 0; k < CH; k++) pix[m_row][m_col][k] = $signed(d[k*DW +: DW]);
        if (m_row % 2 == 1 && m_col % 2 == 1) begin
            for (int k = 0; k < CH; k++) begin
                v0 = pix[m_row-1][m_col-1][k];
                v1 = pix[m_row-1][m_col][k];
                v2 = pix[m_row][m_col-1][k];
                v3 = pix[m_row][m_col][k];
                if (m_mode) begin
                    s   = v0 + v1 + v2 + v3;
                    res = s / 4;
                    if (s < 0 && s % 4 != 0) res = res - 1;
                end else begin
                    res = v0;
                    if (v1 > res) res = v1;
                    if (v2 > res) res = v2;
                    if (v3 > res) res = v3;
                end
                if (m_relu && res < 0) res = 0;
                e.d[k*DW +: DW] = res[DW-1:0];
            end
            e.last = (m_row == H-1 && m_col == W-1);
            q.push_back(e);
        end
        if (m_col == W-1) begin
            m_col = 0;
            m_row = (m_row == H-1) ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
    endtask

    task automatic send(input logic [CH*DW-1:0] d, input bit m, input bit r, input int gap);
        data_in  = d;
        mode_avg = m;
        relu_en  = r;
        valid_in = 1'b1;
        model_beat(d, m, r);
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (gap) begin
            mode_avg = 1'($urandom_range(0, 1));
            relu_en  = 1'($urandom_range(0, 1));
            data_in  = CH*DW'($urandom);
            @(posedge clk); #1;
        end
    endtask

    // A beat presented alongside reset must be discarded.
    task automatic do_reset(input bit with_beat);
        rst      = 1'b1;
        valid_in = with_beat;
        data_in  = CH*DW'($urandom);
        @(posedge clk); #1;
        rst      = 1'b0;
        valid_in = 1'b0;
        m_row    = 0;
        m_col    = 0;
        chk_rst  = 1'b1;
        @(negedge clk); #1;
        chk_rst  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_rst) begin
            n_chk += 3;
            if (data_out !== '0)  begin n_fail++; $display("FAIL reset data_out: got %h expected 0", data_out); end
            if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset valid_out: got %b expected 0", valid_out); end
            if (last_out !== 1'b0)  begin n_fail++; $display("FAIL reset last_out: got %b expected 0", last_out); end
        end
        if (valid_out === 1'b1) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected output: got data %h with empty scoreboard", data_out);
            end else begin
                cur = q.pop_front();
                for (int k = 0; k < CH; k++) begin
                    n_chk++;
                    if (data_out[k*DW +: DW] !== cur.d[k*DW +: DW]) begin
                        n_fail++;
                        $display("FAIL data ch%0d: got %0d expected %0d", k,
                                 $signed(data_out[k*DW +: DW]), $signed(cur.d[k*DW +: DW]));
                    end
                end
                if (last_out !== cur.last) begin
                    n_fail++;
                    $display("FAIL last_out: got %b expected %b", last_out, cur.last);
                end
            end
        end else begin
            n_chk++;
            if (last_out !== 1'b0) begin
                n_fail++;
                $display("FAIL last_out idle: got %b expected 0", last_out);
            end
        end
        if (done) begin
            n_chk++;
            if (q.size() != 0) begin
                n_fail++;
                $display("FAIL missing outputs: got %0d pending expected 0", q.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    initial begin
        n_chk = 0; n_fail = 0; chk_rst = 0; done = 0;
        m_row = 0; m_col = 0; m_mode = 0; m_relu = 0;
        rst = 1'b1; valid_in = 1'b0; mode_avg = 1'b0; relu_en = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0);

        // Max pool with ReLU, then average pool without.
        for (int i = 0; i < 16; i++) send(pk(i+1, -(i+1)), 1'b0, 1'b1, 0);
        for (int i = 0; i < 16; i++) send(pk(i+1, -(i+1)), 1'b1, 1'b0, 0);
        // Floor rounding of negative averages.
        for (int i = 0; i < 16; i++) send(pk((i%2 == 1) ? -2 : -1, (i%2 == 1) ? -2 : -1), 1'b1, 1'b0, 0);
        // Negative max with and without ReLU.
        for (int i = 0; i < 16; i++) send(pk(-5, -5), 1'b0, 1'b0, 0);
        for (int i = 0; i < 16; i++) send(pk(-5, -5), 1'b0, 1'b1, 0);
        // Full-scale averages must not wrap.
        for (int i = 0; i < 16; i++) send(pk(2047, 2047), 1'b1, 1'b0, 0);
        for (int i = 0; i < 16; i++) send(pk(-2048, -2048), 1'b1, 1'b0, 0);
        // Idle gaps, mode toggled mid-frame; new mode only applies to the next frame.
        for (int i = 0; i < 16; i++) send(pk(i+1, -(i+1)), (i >= 4), 1'b1, 3);
        for (int i = 0; i < 16; i++) send(pk(i+1, -(i+1)), 1'b1, 1'b0, 0);
        // Abort after 7 beats, then two back-to-back frames.
        for (int i = 0; i < 7; i++) send(pk(i+1, -(i+1)), 1'b0, 1'b1, 0);
        do_reset(1'b1);
        for (int i = 0; i < 32; i++) send(pk((i%16)+1, -((i%16)+1)), 1'b0, 1'b1, 0);

        // Randomized frames with random gaps, per-beat mode noise and one mid-frame reset.
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 16; i++) begin
                if (f == 4 && i == 9) do_reset(1'b1);
                send(pk(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
            end
        end

        repeat (5) @(posedge clk);
        #1;
        done = 1'b1;
    end
endmodule
